// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller: FSM states,
// the default machine-code width and the HALT opcode (all ones).
package fetch_pkg;

  localparam int unsigned FETCH_INSTR_W = 9;
  localparam logic [FETCH_INSTR_W-1:0] HALT_CODE = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DONE
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating 16-bit event counters for the fetch controller: delivered
// instructions and decode back-pressure cycles. Cleared when a run starts.
module fetch_perf_cnt (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        transfer,
  input  logic        stall,
  output logic [15:0] instr_cnt,
  output logic [15:0] stall_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else if (clear) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (transfer && (instr_cnt != '1)) instr_cnt <= instr_cnt + 16'd1;
      if (stall && (stall_cnt != '1))    stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks the ROM from address 0, hands instructions
// to decode over valid/ready, follows branch redirects and stops on HALT.
// Define FETCH_PERF_EN to add the instr_cnt/stall_cnt performance counters.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned D       = 12,
  parameter int unsigned INSTR_W = FETCH_INSTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [D-1:0]       prog_ctr,
  input  logic [INSTR_W-1:0] mach_code,
  output logic [INSTR_W-1:0] instr,
  output logic [D-1:0]       instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               br_taken,
  input  logic [D-1:0]       br_target,
`ifdef FETCH_PERF_EN
  output logic [15:0]        instr_cnt,
  output logic [15:0]        stall_cnt,
`endif
  output logic               done
);

  // HALT is all ones at whatever width the core is built with.
  localparam logic [INSTR_W-1:0] HaltWord = '1;

  fetch_state_e state_q, state_d;
  logic transfer, redirect, do_load, halt_hit, start_go;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    transfer = instr_valid && instr_ready;
    redirect = 1'b0;
    do_load  = 1'b0;
    halt_hit = 1'b0;
    start_go = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_go = 1'b1;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        // A redirect squashes this edge's sequential fetch, so it also masks HALT.
        redirect = transfer && br_taken;
        if (!redirect && (!instr_valid || instr_ready)) begin
          if (mach_code == HaltWord) begin
            halt_hit = 1'b1;
            state_d  = ST_DONE;
          end else begin
            do_load = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prog_ctr    <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      if (start_go) begin
        prog_ctr <= '0;
        done     <= 1'b0;
      end
      if (transfer) instr_valid <= 1'b0;
      if (redirect) prog_ctr <= br_target;
      if (halt_hit) done <= 1'b1;
      if (do_load) begin
        instr       <= mach_code;
        instr_pc    <= prog_ctr;
        instr_valid <= 1'b1;
        prog_ctr    <= prog_ctr + D'(1);
      end
    end
  end

`ifdef FETCH_PERF_EN
  fetch_perf_cnt u_perf (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_go),
    .transfer (transfer),
    .stall    (instr_valid && !instr_ready),
    .instr_cnt(instr_cnt),
    .stall_cnt(stall_cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed run/stall/branch/reset/wrap
// steps plus a random handshake run checked against a program-flow model.
module tb_fetch_ctrl;

  localparam logic [8:0] HALT = 9'h1FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, instr_ready = 1'b0, br_taken = 1'b0;
  logic [11:0] br_target = '0;
  logic [11:0] prog_ctr, instr_pc;
  logic [8:0]  mach_code, instr;
  logic        instr_valid, done;
  logic [8:0]  rom [0:4095];

  logic        start4 = 1'b0;
  logic [3:0]  prog_ctr4, instr_pc4;
  logic [8:0]  mach_code4, instr4;
  logic        valid4, done4;
  logic [8:0]  rom4 [0:15];

`ifdef FETCH_PERF_EN
  logic [15:0] instr_cnt, stall_cnt, instr_cnt4, stall_cnt4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mach_code  = rom[prog_ctr];
  assign mach_code4 = rom4[prog_ctr4];

  fetch_ctrl #(.D(12), .INSTR_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_ctr(prog_ctr),
    .mach_code(mach_code), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .br_taken(br_taken), .br_target(br_target),
`ifdef FETCH_PERF_EN
    .instr_cnt(instr_cnt), .stall_cnt(stall_cnt),
`endif
    .done(done)
  );

  fetch_ctrl #(.D(4), .INSTR_W(9)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .prog_ctr(prog_ctr4),
    .mach_code(mach_code4), .instr(instr4), .instr_pc(instr_pc4),
    .instr_valid(valid4), .instr_ready(1'b1),
    .br_taken(1'b0), .br_target(4'h0),
`ifdef FETCH_PERF_EN
    .instr_cnt(instr_cnt4), .stall_cnt(stall_cnt4),
`endif
    .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int unsigned exp_pc, n_xfer, n_stall, tgt;
    logic [11:0] prev_pc;
    logic [8:0]  prev_instr;
    logic        prev_stall, rdy, br, found;
    int          n;

    for (int i = 0; i < 4096; i++) rom[i] = 9'(i % 256);
    for (int i = 0; i < 16; i++) rom4[i] = 9'(i + 16);

    // reset state, before any clock edge
    #1;
    check("rst_pc", prog_ctr, 0);
    check("rst_instr", instr, 0);
    check("rst_ipc", instr_pc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_done", done, 0);
    check("rst_pc4", prog_ctr4, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("idle_hold_pc", prog_ctr, 0);
    check("idle_valid", instr_valid, 0);

    // straight-line run ending on HALT
    rom[0] = 9'h010; rom[1] = 9'h011; rom[2] = 9'h012; rom[3] = HALT;
    instr_ready = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("run_e0_pc", prog_ctr, 0);
    check("run_e0_valid", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check("run_valid", instr_valid, 1);
      check("run_ipc", instr_pc, i);
      check("run_instr", instr, rom[i]);
    end
    check("run_pc3", prog_ctr, 3);
    tick;
    check("halt_done", done, 1);
    check("halt_valid", instr_valid, 0);
    check("halt_pc", prog_ctr, 3);
    tick;
    check("done_hold_pc", prog_ctr, 3);
    check("done_hold", done, 1);

    // back-pressure at instr_pc=1, restarted from DONE
    rom[3] = 9'h013;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("restart_done", done, 0);
    check("restart_pc", prog_ctr, 0);
    tick;
    check("st_ipc0", instr_pc, 0);
    tick;
    check("st_ipc1", instr_pc, 1);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("st_valid", instr_valid, 1);
      check("st_ipc", instr_pc, 1);
      check("st_instr", instr, rom[1]);
      check("st_pc", prog_ctr, 2);
    end
`ifdef FETCH_PERF_EN
    check("st_stall_cnt", stall_cnt, 3);
    check("st_instr_cnt", instr_cnt, 1);
`endif

    // branch on the transfer of instr_pc=2
    instr_ready = 1'b1;
    tick;
    check("br_ipc2", instr_pc, 2);
    br_taken = 1'b1;
    br_target = 12'h040;
    tick;
    br_taken = 1'b0;
    check("br_squash", instr_valid, 0);
    check("br_pc", prog_ctr, 12'h040);
    tick;
    check("br_valid", instr_valid, 1);
    check("br_ipc", instr_pc, 12'h040);
    check("br_instr", instr, rom[12'h040]);

    // asynchronous reset mid-run at prog_ctr=5
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    tick;
    start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (prog_ctr == 12'd5) found = 1'b1;
      else tick;
    end
    check("mid_reach5", found, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_pc", prog_ctr, 0);
    check("arst_instr", instr, 0);
    check("arst_ipc", instr_pc, 0);
    check("arst_valid", instr_valid, 0);
    check("arst_done", done, 0);
`ifdef FETCH_PERF_EN
    check("arst_icnt", instr_cnt, 0);
    check("arst_scnt", stall_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    check("rs_valid", instr_valid, 1);
    check("rs_ipc", instr_pc, 0);

    // D=4 instance: wrap, start ignored in FETCH, HALT, start from DONE
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    exp_pc = 0;
    n = 0;
    for (int c = 0; c < 80 && !done4; c++) begin
      tick;
      start4 = 1'b0;
      if (valid4) begin
        check("d4_seq", instr_pc4, exp_pc);
        exp_pc = (exp_pc + 1) % 16;
        n++;
        if (n == 8) start4 = 1'b1;
        if (n == 20) rom4[6] = HALT;
      end
    end
    check("d4_ntrans", n, 22);
    check("d4_done", done4, 1);
    check("d4_valid", valid4, 0);
    check("d4_halt_pc", prog_ctr4, 6);
    rom4[6] = 9'h016;
    start4 = 1'b1;
    tick;
    start4 = 1'b0;
    check("d4_rs_done", done4, 0);
    check("d4_rs_pc", prog_ctr4, 0);
    tick;
    check("d4_rs_valid", valid4, 1);
    check("d4_rs_ipc", instr_pc4, 0);

    // random handshake/branch run against the program-flow model
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++)
      rom[i] = ($urandom % 12 == 0) ? HALT : 9'($urandom_range(0, 510));
    rom[0] = 9'h055;
    rom[31] = HALT;
    @(negedge clk);
    start = 1'b1;
    tick;
    start = 1'b0;
    exp_pc = 0;
    n_xfer = 0;
    n_stall = 0;
    prev_stall = 1'b0;
    prev_pc = '0;
    prev_instr = '0;
    for (int c = 0; c < 800; c++) begin
      if (prev_stall) begin
        check("rnd_hold_valid", instr_valid, 1);
        check("rnd_hold_ipc", instr_pc, prev_pc);
        check("rnd_hold_instr", instr, prev_instr);
      end
      if (done) break;
      rdy = ($urandom % 4) != 0;
      br  = ($urandom % 6) == 0;
      tgt = $urandom_range(0, 30);
      instr_ready = rdy;
      br_taken = br;
      br_target = 12'(tgt);
      prev_stall = instr_valid && !rdy;
      prev_pc = instr_pc;
      prev_instr = instr;
      if (prev_stall) n_stall++;
      if (instr_valid && rdy) begin
        check("rnd_ipc", instr_pc, exp_pc);
        check("rnd_instr", instr, rom[exp_pc]);
        exp_pc = br ? tgt : exp_pc + 1;
        n_xfer++;
      end
      tick;
    end
    check("rnd_done", done, 1);
    check("rnd_valid", instr_valid, 0);
    check("rnd_halt_pc", prog_ctr, exp_pc);
`ifdef FETCH_PERF_EN
    check("rnd_icnt", instr_cnt, n_xfer);
    check("rnd_scnt", stall_cnt, n_stall);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
